// File: rtl/soc_bus_pkg.sv
// -----------------------------------------------------------------------------
// soc_bus_pkg
//   Shared types and constants for the single-master data-bus interconnect.
//   - bus_state_e : interconnect FSM encoding (IDLE / ACTIVE / RESP)
//   - default address map for the 4-slot build:
//       slot 0 RAM  : base 32'h0000_0000, mask 32'hFFFF_0000
//       slot 1 MMIO : base 32'hFFFF_0000, mask 32'hFFFF_0000
//       slot 2/3    : unused (mask 0 with a non-zero base can never match)
//   - DEF_ERR_RDATA : read data returned on an errored access
//   - sel_width()   : width of a slave index for a given slave count
// -----------------------------------------------------------------------------
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK   = 32'hFFFF_0000;

  // (addr & 0) is always 0, so a non-zero base makes the slot unreachable.
  localparam logic [31:0] UNUSED_BASE = 32'hFFFF_FFFF;
  localparam logic [31:0] UNUSED_MASK = 32'h0000_0000;

  localparam logic [127:0] DEF_SLV_BASE = {UNUSED_BASE, UNUSED_BASE, MMIO_BASE, RAM_BASE};
  localparam logic [127:0] DEF_SLV_MASK = {UNUSED_MASK, UNUSED_MASK, MMIO_MASK, RAM_MASK};

  localparam logic [31:0] DEF_ERR_RDATA = 32'h0000_0000;

  // Index width; a single-slave build still carries a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_addr_dec.sv
// -----------------------------------------------------------------------------
// soc_bus_addr_dec
//   Purely combinational priority address decoder. Slot i hits when
//   (i_addr & MASK_i) == BASE_i; when several slots hit, the lowest index wins.
// Ports
//   i_addr : byte address to decode
//   o_hit  : at least one slot matched
//   o_sel  : index of the lowest matching slot (0 when no hit)
// -----------------------------------------------------------------------------
module soc_bus_addr_dec
  import soc_bus_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter int                  AW       = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*AW-1:0] SLV_MASK = '0,
  parameter int                  SW       = sel_width(N_SLV)
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_hit,
  output logic [SW-1:0] o_sel
);

  // Scan from the top down so the last assignment is the lowest match.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((i_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        o_hit = 1'b1;
        o_sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/soc_bus_ic.sv
// -----------------------------------------------------------------------------
// soc_bus_ic
//   Single-master, N-slave data-bus interconnect. A master request is latched
//   in IDLE, decoded to one slave region, forwarded as a one-hot s_req, and
//   completed with a one-cycle m_ready pulse (m_err flags unmapped accesses and,
//   when enabled, timed-out ones).
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   : ACTIVE aborts with m_err after TIMEOUT_CYC cycles without
//                 s_ready from the selected slave.
//     undefined : ACTIVE waits for the slave indefinitely.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   m_req/m_we/m_wstrb/m_addr/m_wdata   master request (held until m_ready)
//   m_rdata/m_ready/m_err               master response (valid with m_ready)
//   busy                transaction in flight (state != IDLE)
//   s_req               one-hot slave request
//   s_we/s_wstrb/s_addr/s_wdata         latched request, shared by all slaves
//   s_rdata/s_ready     packed slave read data / per-slave completion
//
// Timing: accept at edge 0, zero-wait slave -> m_ready after edge 2,
// unmapped -> m_ready after edge 1. m_ready is produced while leaving RESP,
// so the pulse coincides with the IDLE cycle that can accept the next request.
// -----------------------------------------------------------------------------
module soc_bus_ic
  import soc_bus_pkg::*;
#(
  parameter int                  N_SLV       = 4,
  parameter int                  AW          = 32,
  parameter int                  DW          = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE    = DEF_SLV_BASE,
  parameter logic [N_SLV*AW-1:0] SLV_MASK    = DEF_SLV_MASK,
  parameter int                  TIMEOUT_CYC = 255,
  parameter logic [DW-1:0]       ERR_RDATA   = DW'(DEF_ERR_RDATA)
) (
  input  logic                clk,
  input  logic                rst_n,
  // master side
  input  logic                m_req,
  input  logic                m_we,
  input  logic [DW/8-1:0]     m_wstrb,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_wdata,
  output logic [DW-1:0]       m_rdata,
  output logic                m_ready,
  output logic                m_err,
  output logic                busy,
  // slave side
  output logic [N_SLV-1:0]    s_req,
  output logic                s_we,
  output logic [DW/8-1:0]     s_wstrb,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  input  logic [N_SLV*DW-1:0] s_rdata,
  input  logic [N_SLV-1:0]    s_ready
);

  localparam int SW = sel_width(N_SLV);

  bus_state_e          r_state;
  logic [SW-1:0]       r_sel;
  logic                r_err;
  logic [N_SLV-1:0]    r_sreq;
  logic                r_we;
  logic [DW/8-1:0]     r_wstrb;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_rdata;
  logic                r_mready;
  logic                r_merr;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]       r_cnt;
`endif

  logic                w_hit;
  logic [SW-1:0]       w_sel;
  logic [N_SLV-1:0]    w_onehot;
  logic                w_sel_rdy;
  logic [DW-1:0]       w_sel_rdata;

  // Decode the live master address; only consulted while IDLE.
  soc_bus_addr_dec #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .SW       (SW)
  ) u_dec (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  assign w_onehot    = N_SLV'(1) << w_sel;
  // Only the latched selection is looked at; other slaves' ready is ignored.
  assign w_sel_rdy   = s_ready[r_sel];
  assign w_sel_rdata = s_rdata[int'(r_sel)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_err    <= 1'b0;
      r_sreq   <= '0;
      r_we     <= 1'b0;
      r_wstrb  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_mready <= 1'b0;
      r_merr   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      // Response qualifiers are single-cycle pulses.
      r_mready <= 1'b0;
      r_merr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_req) begin
            r_we    <= m_we;
            r_wstrb <= m_wstrb;
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_sel   <= w_sel;
            if (w_hit) begin
              r_sreq  <= w_onehot;
              r_err   <= 1'b0;
              r_state <= ST_ACTIVE;
`ifdef BUS_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end else begin
              // Unmapped: no slave is ever requested, writes are dropped.
              r_err   <= 1'b1;
              r_rdata <= ERR_RDATA;
              r_state <= ST_RESP;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_sel_rdy) begin
            // Completion beats a timeout landing in the same cycle.
            r_rdata <= w_sel_rdata;
            r_err   <= 1'b0;
            r_sreq  <= '0;
            r_state <= ST_RESP;
          end
`ifdef BUS_TIMEOUT_EN
          // Count reaches TIMEOUT_CYC on this cycle -> abort.
          else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
            r_sreq  <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          // m_req is deliberately not looked at here.
          r_mready <= 1'b1;
          r_merr   <= r_err;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign m_ready = r_mready;
  assign m_err   = r_merr;
  assign m_rdata = r_rdata;
  assign s_req   = r_sreq;
  assign s_we    = r_we;
  assign s_wstrb = r_wstrb;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;

endmodule
